// File: rtl/tdm_pkg.sv
// tdm_pkg: shared sizes and FSM state type for the TDM link scheduler
package tdm_pkg;
  localparam int N_CH = 4;
  localparam int MSG_W = 4;
  localparam int CH_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(MSG_W);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: combinational round-robin pick starting after last_grant
module rr_arbiter_4
  import tdm_pkg::*;
(
  input  logic [N_CH-1:0] eligible,
  input  logic [CH_W-1:0] last_grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            grant_any
);
  logic [CH_W-1:0] cand;
  always_comb begin
    grant_idx = '0;
    cand = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = last_grant + CH_W'(k);
      grant_idx = eligible[cand] ? cand : grant_idx;
    end
    grant_any = |eligible;
  end
endmodule

// File: rtl/tdm_link_scheduler.sv
// tdm_link_scheduler: round-robin TDM serialiser/deserialiser over a shared 1-bit link
module tdm_link_scheduler
  import tdm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       req_valid,
  input  logic [N_CH*MSG_W-1:0] req_msg,
  output logic [N_CH-1:0]       req_ready,
  output logic [CH_W-1:0]       link_sel,
  output logic                  link_bit,
  output logic                  link_en,
  output logic                  out_valid,
  output logic [CH_W-1:0]       out_ch,
  output logic [MSG_W-1:0]      out_msg,
  output logic                  busy
);
  state_t state, state_nx;
  logic [CNT_W-1:0] bit_cnt;
  logic [MSG_W-1:0] tx_sh, rx_sh, msg_q;
  logic [CH_W-1:0] last_grant, grant_idx, ch_q;
  logic grant_any, take;
  rr_arbiter_4 u_arb (
    .eligible(req_valid & ch_en),
    .last_grant(last_grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );
  assign take = rst_n && state == IDLE && grant_any;
  always_comb begin
    req_ready = '0;
    req_ready[grant_idx] = take;
    link_en = state == SEND;
    link_bit = link_en & tx_sh[0];
    out_valid = state == DONE;
    busy = state != IDLE;
    out_msg = out_valid ? rx_sh : msg_q;
    out_ch = out_valid ? link_sel : ch_q;
    state_nx = take ? SEND
             : (state == SEND && bit_cnt == CNT_W'(MSG_W-1)) ? DONE
             : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) state <= rst_n ? state_nx : IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      msg_q <= '0;
      ch_q <= '0;
      link_sel <= '0;
      last_grant <= CH_W'(N_CH-1);
    end else begin
      bit_cnt <= link_en ? bit_cnt + 1'b1 : '0;
      tx_sh <= take ? req_msg[grant_idx*MSG_W +: MSG_W] : tx_sh >> 1;
      rx_sh <= link_en ? {link_bit, rx_sh[MSG_W-1:1]} : rx_sh;
      if (take) begin
        last_grant <= grant_idx;
        link_sel <= grant_idx;
      end
      if (out_valid) begin
        msg_q <= rx_sh;
        ch_q <= link_sel;
      end
    end
  end
endmodule

// File: tb/tb_tdm_link_scheduler.sv
// tb_tdm_link_scheduler: directed self-checking bench for the TDM link scheduler
module tb_tdm_link_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] ch_en, req_valid, req_ready;
  logic [15:0] req_msg;
  logic [1:0] link_sel, out_ch;
  logic link_bit, link_en, out_valid, busy;
  logic [3:0] out_msg;
  int vectors = 0;
  int errors = 0;
  tdm_link_scheduler dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .req_valid(req_valid), .req_msg(req_msg),
    .req_ready(req_ready), .link_sel(link_sel), .link_bit(link_bit), .link_en(link_en),
    .out_valid(out_valid), .out_ch(out_ch), .out_msg(out_msg), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, ".ready"}, req_ready, 0);
    chk({tag, ".en"}, link_en, 0);
    chk({tag, ".bit"}, link_bit, 0);
    chk({tag, ".ov"}, out_valid, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask
  task automatic slot(input logic [1:0] g, input logic [3:0] m, input bit drop);
    #1;
    chk("grant.ready", req_ready, 32'd1 << g);
    chk("grant.busy", busy, 0);
    tick;
    if (drop) req_valid[g] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("send.sel", link_sel, g);
      chk("send.en", link_en, 1);
      chk("send.bit", link_bit, m[i]);
      chk("send.ready", req_ready, 0);
      tick;
    end
    #1;
    chk("done.ov", out_valid, 1);
    chk("done.ch", out_ch, g);
    chk("done.msg", out_msg, m);
    chk("done.en", link_en, 0);
    tick;
  endtask
  initial begin
    rst_n = 1'b0;
    ch_en = 4'hF;
    req_valid = 4'hF;
    req_msg = 16'hFFFF;
    repeat (3) begin
      tick;
      #1;
      chk_quiet("rst");
      chk("rst.sel", link_sel, 0);
      chk("rst.och", out_ch, 0);
      chk("rst.omsg", out_msg, 0);
    end
    rst_n = 1'b1;
    req_valid = 4'b0100;
    req_msg = 16'h0B00;
    slot(2'd2, 4'b1011, 1'b1);
    #1;
    chk("hold.ov", out_valid, 0);
    chk("hold.ch", out_ch, 2);
    chk("hold.msg", out_msg, 4'b1011);
    chk("hold.sel", link_sel, 2);
    chk("hold.busy", busy, 0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    req_valid = 4'hF;
    req_msg = 16'h4321;
    slot(2'd0, 4'h1, 1'b1);
    slot(2'd1, 4'h2, 1'b1);
    slot(2'd2, 4'h3, 1'b1);
    slot(2'd3, 4'h4, 1'b1);
    ch_en = 4'b1101;
    req_valid = 4'hF;
    slot(2'd0, 4'h1, 1'b0);
    slot(2'd2, 4'h3, 1'b0);
    slot(2'd3, 4'h4, 1'b0);
    slot(2'd0, 4'h1, 1'b0);
    slot(2'd2, 4'h3, 1'b0);
    ch_en = 4'hF;
    req_valid = 4'b1000;
    req_msg = 16'hA321;
    #1;
    chk("abort.ready", req_ready, 4'b1000);
    tick;
    req_valid = 4'b0000;
    tick;
    tick;
    #1;
    chk("abort.bit2", link_en, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    repeat (6) begin
      #1;
      chk_quiet("abort");
      chk("abort.omsg", out_msg, 0);
      tick;
    end
    req_valid = 4'b1001;
    slot(2'd0, 4'h1, 1'b1);
    slot(2'd3, 4'hA, 1'b1);
    req_valid = 4'b1001;
    slot(2'd0, 4'h1, 1'b1);
    slot(2'd3, 4'hA, 1'b1);
    #1;
    chk_quiet("end");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
